wb_csr_file_ysyx_23060136: RTL

WB_CSR_FILE_YSYX_23060136 -- requirements
Module: WB_CSR_FILE_ysyx_23060136

---
 rtl/wb_csr_file_ysyx_23060136.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_csr_file_ysyx_23060136.sv
// Machine-mode CSR file for the ysyx core: WB commit port, combinational read port,
// ecall/mret trap sequencing with a one-cycle fetch redirect, and 64-bit mcycle/minstret.
module wb_csr_file_ysyx_23060136 (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] CSR_rd_addr,
  output logic [31:0] CSR_rs_data,
  input  logic        WB_CSR_valid,
  output logic        WB_CSR_ready,
  input  logic [11:0] WB_CSR_addr,
  input  logic [31:0] WB_CSR_wdata,
  input  logic        WB_CSR_wen,
  input  logic        WB_CSR_ecall,
  input  logic        WB_CSR_mret,
  input  logic [31:0] WB_CSR_pc,
  output logic        CSR_redirect_valid,
  output logic [31:0] CSR_redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  localparam logic [31:0] MVENDORID_VAL  = 32'h7973_7978;
  localparam logic [31:0] MARCHID_VAL    = 32'h015F_DEA8;
  localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TRAP = 2'b01,
    RET  = 2'b10
  } state_t;

  // Word-align a target address (direct-mode mtvec, 32-bit instructions).
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  function automatic logic [31:0] mstatus_pack(input logic mpie, input logic mie);
    return {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic        ready_r;
  logic        ready_s;
  logic        redirect_valid_r;
  logic        redirect_valid_s;
  logic [31:0] redirect_pc_r;
  logic [31:0] redirect_pc_s;

  logic        mie_r;
  logic        mie_s;
  logic        mpie_r;
  logic        mpie_s;
  logic [31:0] mtvec_r;
  logic [31:0] mtvec_s;
  logic [31:0] mepc_r;
  logic [31:0] mepc_s;
  logic [31:0] mcause_r;
  logic [31:0] mcause_s;
  logic [63:0] mcycle_r;
  logic [63:0] mcycle_s;
  logic [63:0] minstret_r;
  logic [63:0] minstret_s;

  logic        accept_s;
  logic        do_ecall_s;
  logic        do_mret_s;
  logic        do_write_s;

  // Commit decode; ecall outranks mret, which outranks a plain CSR write.
  always_comb begin
    accept_s   = WB_CSR_valid && ready_r;
    do_ecall_s = accept_s && WB_CSR_ecall;
    do_mret_s  = accept_s && !WB_CSR_ecall && WB_CSR_mret;
    do_write_s = accept_s && !WB_CSR_ecall && !WB_CSR_mret && WB_CSR_wen;
  end

  // Trap sequencer next state and the registered handshake/redirect values.
  always_comb begin
    state_s          = state_r;
    ready_s          = 1'b1;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'd0;
    case (state_r)
      IDLE: begin
        if (do_ecall_s) begin
          state_s          = TRAP;
          ready_s          = 1'b0;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = mtvec_r;
        end else if (do_mret_s) begin
          state_s          = RET;
          ready_s          = 1'b0;
          redirect_valid_s = 1'b1;
          redirect_pc_s    = mepc_r;
        end else begin
          state_s = IDLE;
        end
      end
      TRAP:    state_s = IDLE;
      RET:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Architectural CSR updates; writes to read-only or unknown addresses fall through.
  always_comb begin
    mie_s    = mie_r;
    mpie_s   = mpie_r;
    mtvec_s  = mtvec_r;
    mepc_s   = mepc_r;
    mcause_s = mcause_r;
    if (do_ecall_s) begin
      mepc_s   = align_word(WB_CSR_pc);
      mcause_s = CAUSE_ECALL_M;
      mpie_s   = mie_r;
      mie_s    = 1'b0;
    end else if (do_mret_s) begin
      mie_s  = mpie_r;
      mpie_s = 1'b1;
    end else if (do_write_s) begin
      case (WB_CSR_addr)
        ADDR_MSTATUS: begin
          mie_s  = WB_CSR_wdata[3];
          mpie_s = WB_CSR_wdata[7];
        end
        ADDR_MTVEC:  mtvec_s  = align_word(WB_CSR_wdata);
        ADDR_MEPC:   mepc_s   = align_word(WB_CSR_wdata);
        ADDR_MCAUSE: mcause_s = WB_CSR_wdata;
        default:     mcause_s = mcause_r;
      endcase
    end else begin
      mcause_s = mcause_r;
    end
  end

  // Counters: a write to either half replaces that cycle's increment of the whole counter.
  always_comb begin
    mcycle_s   = mcycle_r + 64'd1;
    minstret_s = accept_s ? (minstret_r + 64'd1) : minstret_r;
    if (do_write_s) begin
      case (WB_CSR_addr)
        ADDR_MCYCLE:    mcycle_s   = {mcycle_r[63:32], WB_CSR_wdata};
        ADDR_MCYCLEH:   mcycle_s   = {WB_CSR_wdata, mcycle_r[31:0]};
        ADDR_MINSTRET:  minstret_s = {minstret_r[63:32], WB_CSR_wdata};
        ADDR_MINSTRETH: minstret_s = {WB_CSR_wdata, minstret_r[31:0]};
        default:        minstret_s = minstret_r + 64'd1;
      endcase
    end else begin
      mcycle_s = mcycle_r + 64'd1;
    end
  end

  // Combinational read port straight from the register state, no bypass.
  always_comb begin
    case (CSR_rd_addr)
      ADDR_MSTATUS:   CSR_rs_data = mstatus_pack(mpie_r, mie_r);
      ADDR_MTVEC:     CSR_rs_data = mtvec_r;
      ADDR_MEPC:      CSR_rs_data = mepc_r;
      ADDR_MCAUSE:    CSR_rs_data = mcause_r;
      ADDR_MCYCLE:    CSR_rs_data = mcycle_r[31:0];
      ADDR_MCYCLEH:   CSR_rs_data = mcycle_r[63:32];
      ADDR_MINSTRET:  CSR_rs_data = minstret_r[31:0];
      ADDR_MINSTRETH: CSR_rs_data = minstret_r[63:32];
      ADDR_MVENDORID: CSR_rs_data = MVENDORID_VAL;
      ADDR_MARCHID:   CSR_rs_data = MARCHID_VAL;
      default:        CSR_rs_data = 32'd0;
    endcase
  end

  // Sequencer and output registers; reset drops any in-flight redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      ready_r          <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'd0;
    end else begin
      state_r          <= state_s;
      ready_r          <= ready_s;
      redirect_valid_r <= redirect_valid_s;
      redirect_pc_r    <= redirect_pc_s;
    end
  end

  // CSR and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= 32'd0;
      mepc_r     <= 32'd0;
      mcause_r   <= 32'd0;
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      mie_r      <= mie_s;
      mpie_r     <= mpie_s;
      mtvec_r    <= mtvec_s;
      mepc_r     <= mepc_s;
      mcause_r   <= mcause_s;
      mcycle_r   <= mcycle_s;
      minstret_r <= minstret_s;
    end
  end

  assign WB_CSR_ready       = ready_r;
  assign CSR_redirect_valid = redirect_valid_r;
  assign CSR_redirect_pc    = redirect_pc_r;

endmodule
